snake_head_stepper: RTL and testbench

- Sits directly downstream of the Direction block.
- Consumes its registered 4-bit direction code and advances the snake head one grid cell per game tick.
- Detects wall collisions and raises game_over.
- Feeds head coordinates plus a one-cycle step strobe to the body/renderer stages.

---
 rtl/snake_pkg.sv | 27 ++
 rtl/snake_tick_gen.sv | 38 +++
 rtl/snake_head_stepper.sv | 112 +++++++++++
 tb/tb_snake_head_stepper.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game datapath: direction codes,
// head-stepper state encoding and default board/clock settings.
package snake_pkg;

   localparam logic [3:0] DIR_NONE  = 4'b0000;
   localparam logic [3:0] DIR_DOWN  = 4'b0001;
   localparam logic [3:0] DIR_UP    = 4'b0010;
   localparam logic [3:0] DIR_RIGHT = 4'b0100;
   localparam logic [3:0] DIR_LEFT  = 4'b1000;

   localparam int GRID_W     = 32;
   localparam int GRID_H     = 24;
   localparam int CLOCK_FREQ = 50_000_000;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUN       = 2'd1,
      GAME_OVER = 2'd2
   } state_t;

   // Only the four single-bit codes count as a movement request.
   function automatic logic dir_legal(input logic [3:0] dir);
      return (dir == DIR_DOWN) || (dir == DIR_UP) ||
             (dir == DIR_RIGHT) || (dir == DIR_LEFT);
   endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Modulo-TICK_DIV game tick counter: counts while enabled, clears to zero
// on request, and pulses tick combinationally on the terminal count.
module snake_tick_gen #(
   parameter int TICK_DIV = 5_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = $clog2(TICK_DIV);

   logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
   logic             at_last;

   assign at_last = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
   assign tick    = en && at_last;

   always_comb begin
      tick_cnt_d = tick_cnt_q;
      if (clr) begin
         tick_cnt_d = '0;
      end else if (en) begin
         tick_cnt_d = at_last ? '0 : tick_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
      end
   end

endmodule

// File: rtl/snake_head_stepper.sv
// Advances the snake head one cell per game tick in the requested direction,
// stopping with a sticky game_over when the move would leave the grid.
module snake_head_stepper
   import snake_pkg::*;
#(
   parameter int GRID_W   = snake_pkg::GRID_W,
   parameter int GRID_H   = snake_pkg::GRID_H,
   parameter int X_W      = 5,
   parameter int Y_W      = 5,
   parameter int TICK_DIV = snake_pkg::CLOCK_FREQ / 10,
   parameter int START_X  = 16,
   parameter int START_Y  = 12
) (
   input  logic           clock,
   input  logic           reset,
   input  logic [3:0]     direction,
   input  logic           pause,
   output logic [X_W-1:0] head_x,
   output logic [Y_W-1:0] head_y,
   output logic           step_valid,
   output logic           game_over
);

   state_t         state_q, state_d;
   logic [X_W-1:0] head_x_q, head_x_d;
   logic [Y_W-1:0] head_y_q, head_y_d;
   logic           step_valid_q, step_valid_d;
   logic           game_over_q, game_over_d;
   logic           tick;
   logic           blocked;

   snake_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clock (clock),
      .reset (reset),
      .en    ((state_q == RUN) && !pause),
      .clr   (state_q == IDLE),
      .tick  (tick)
   );

   // Edge test happens on the current head so the add/subtract never wraps.
   always_comb begin
      blocked = 1'b0;
      unique case (direction)
         DIR_DOWN:  blocked = (head_y_q == Y_W'(GRID_H - 1));
         DIR_UP:    blocked = (head_y_q == '0);
         DIR_RIGHT: blocked = (head_x_q == X_W'(GRID_W - 1));
         DIR_LEFT:  blocked = (head_x_q == '0);
         default:   blocked = 1'b0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      head_x_d     = head_x_q;
      head_y_d     = head_y_q;
      step_valid_d = 1'b0;
      game_over_d  = game_over_q;
      unique case (state_q)
         IDLE: begin
            if (dir_legal(direction)) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (tick && dir_legal(direction)) begin
               if (blocked) begin
                  game_over_d = 1'b1;
                  state_d     = GAME_OVER;
               end else begin
                  step_valid_d = 1'b1;
                  unique case (direction)
                     DIR_DOWN:  head_y_d = head_y_q + Y_W'(1);
                     DIR_UP:    head_y_d = head_y_q - Y_W'(1);
                     DIR_RIGHT: head_x_d = head_x_q + X_W'(1);
                     default:   head_x_d = head_x_q - X_W'(1);
                  endcase
               end
            end
         end
         GAME_OVER: begin
            game_over_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         head_x_q     <= X_W'(START_X);
         head_y_q     <= Y_W'(START_Y);
         step_valid_q <= 1'b0;
         game_over_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         head_x_q     <= head_x_d;
         head_y_q     <= head_y_d;
         step_valid_q <= step_valid_d;
         game_over_q  <= game_over_d;
      end
   end

   assign head_x     = head_x_q;
   assign head_y     = head_y_q;
   assign step_valid = step_valid_q;
   assign game_over  = game_over_q;

endmodule

// File: tb/tb_snake_head_stepper.sv
// Directed bench for snake_head_stepper on a small 8x6 board with a 4-cycle tick.
module tb_snake_head_stepper;

   logic       clock;
   logic       reset;
   logic [3:0] direction;
   logic       pause;
   logic [2:0] head_x;
   logic [2:0] head_y;
   logic       step_valid;
   logic       game_over;

   int checks = 0;
   int errors = 0;
   int n_cyc;
   int n_sv;

   snake_head_stepper #(
      .GRID_W   (8),
      .GRID_H   (6),
      .X_W      (3),
      .Y_W      (3),
      .TICK_DIV (4),
      .START_X  (4),
      .START_Y  (3)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .direction  (direction),
      .pause      (pause),
      .head_x     (head_x),
      .head_y     (head_y),
      .step_valid (step_valid),
      .game_over  (game_over)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int x, input int y,
                          input int sv, input int go);
      chk({tag, "_x"}, int'(head_x), x);
      chk({tag, "_y"}, int'(head_y), y);
      chk({tag, "_sv"}, int'(step_valid), sv);
      chk({tag, "_go"}, int'(game_over), go);
   endtask

   // Run n cycles, sampling 1 ns after each edge, counting step_valid pulses.
   task automatic run(input int n, output int sv_cnt);
      sv_cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
         if (step_valid) sv_cnt++;
      end
   endtask

   // Wait (bounded) for step_valid (which=0) or game_over (which=1);
   // returns cycles taken (limit+1 on timeout) and step pulses seen on the way.
   task automatic wait_for(input int which, input int limit,
                           output int cyc, output int sv_cnt);
      cyc    = limit + 1;
      sv_cnt = 0;
      for (int i = 1; i <= limit; i++) begin
         @(posedge clock);
         #1;
         if (which == 0 ? step_valid : game_over) begin
            cyc = i;
            break;
         end
         if (step_valid) sv_cnt++;
      end
   endtask

   task automatic async_reset(input string tag);
      @(posedge clock);
      #3;
      reset     = 1'b1;
      direction = 4'b0000;
      pause     = 1'b0;
      #1;
      chk_out(tag, 4, 3, 0, 0);
      #2;
      reset = 1'b0;
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      direction = 4'b0000;
      pause     = 1'b0;
      #12;
      chk_out("reset", 4, 3, 0, 0);
      reset = 1'b0;

      // Idle with no direction: nothing moves.
      run(20, n_sv);
      chk("idle_sv_count", n_sv, 0);
      chk_out("idle", 4, 3, 0, 0);

      // RIGHT to the east wall.
      direction = 4'b0100;
      wait_for(0, 10, n_cyc, n_sv);
      chk("right1_lat", n_cyc, 5);
      chk("right1_x", int'(head_x), 5);
      run(1, n_sv);
      chk("right1_pulse_width", n_sv, 0);
      wait_for(0, 10, n_cyc, n_sv);
      chk("right2_lat", n_cyc, 3);
      chk("right2_x", int'(head_x), 6);
      wait_for(0, 10, n_cyc, n_sv);
      chk("right3_lat", n_cyc, 4);
      chk_out("right3", 7, 3, 1, 0);
      wait_for(1, 10, n_cyc, n_sv);
      chk("right_wall_lat", n_cyc, 4);
      chk_out("right_wall", 7, 3, 0, 1);
      run(10, n_sv);
      chk("gameover_sv_count", n_sv, 0);
      chk_out("gameover_hold", 7, 3, 0, 1);

      // Asynchronous reset mid-cycle from GAME_OVER, then a fresh RIGHT move.
      async_reset("areset_go");
      direction = 4'b0100;
      wait_for(0, 10, n_cyc, n_sv);
      chk("restart_lat", n_cyc, 5);
      chk_out("restart", 5, 3, 1, 0);

      // DOWN to the bottom edge; GAME_OVER then ignores direction.
      async_reset("areset_down");
      direction = 4'b0001;
      wait_for(0, 10, n_cyc, n_sv);
      chk("down1_lat", n_cyc, 5);
      chk_out("down1", 4, 4, 1, 0);
      wait_for(0, 10, n_cyc, n_sv);
      chk("down2_lat", n_cyc, 4);
      chk("down2_y", int'(head_y), 5);
      wait_for(1, 10, n_cyc, n_sv);
      chk("bottom_wall_lat", n_cyc, 4);
      chk_out("bottom_wall", 4, 5, 0, 1);
      direction = 4'b0010;
      run(8, n_sv);
      chk("gameover_up_sv_count", n_sv, 0);
      chk_out("gameover_up", 4, 5, 0, 1);

      // LEFT with a 10-cycle pause while the counter sits at 2.
      async_reset("areset_left");
      direction = 4'b1000;
      run(3, n_sv);
      pause = 1'b1;
      run(10, n_sv);
      chk("pause_sv_count", n_sv, 0);
      chk_out("pause_hold", 4, 3, 0, 0);
      pause = 1'b0;
      wait_for(0, 10, n_cyc, n_sv);
      chk("resume_lat", n_cyc, 2);
      chk_out("resume", 3, 3, 1, 0);

      // Illegal code on a tick: no move, no game over; counter keeps cycling.
      direction = 4'b0011;
      run(4, n_sv);
      chk("illegal_sv_count", n_sv, 0);
      chk_out("illegal", 3, 3, 0, 0);
      direction = 4'b1000;
      wait_for(0, 10, n_cyc, n_sv);
      chk("left_after_illegal_lat", n_cyc, 4);
      chk_out("left_after_illegal", 2, 3, 1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
